sram_axi_bridge: RTL and testbench
==================================

// Module: sram_axi_bridge
// PURPOSE
//  Converts the core's two SRAM-like ports (inst, data: req/addr_ok/data_ok) into one AXI3 master.
//  Sits between the CPU top level and the AXI interconnect.
//  Successor to the fixed single-outstanding bridge: parametrised width and read depth.
//  Adds per-port outstanding-read tracking and data-port read/write ordering.
// PARAMETERS
//  ADDR_W          32  address width of both SRAM-like ports and AXI AR/AW
//  DATA_W          32  data width; wstrb width = DATA_W/8
//  RD_OUTSTANDING  2   max in-flight reads per port (>=1)
//  ID_INST         0   AXI ARID used for inst-port reads
//  ID_DATA         1   AXI ARID/AWID/WID used for data-port accesses
// PORTS
//  clk        in  1  single clock, all logic on rising edge
//  resetn     in  1  asynchronous, active-low reset
//  inst_sram_{req,wr,size,wstrb,addr,wdata}  in   1/1/2/DATA_W/8/ADDR_W/DATA_W  inst request; wr must be 0
//  inst_sram_{addr_ok,data_ok}               out  1/1                            accept / return pulse
//  inst_sram_rdata                           out  DATA_W                         read data, valid with data_ok
//  data_sram_{req,wr,size,wstrb,addr,wdata}  in   as inst                        data request
//  data_sram_{addr_ok,data_ok}               out  1/1                            accept / completion (rd or wr)
//  data_sram_rdata                           out  DATA_W                         read data, valid with data_ok
//  arid,araddr,arlen,arsize,arburst,arlock,arcache,arprot,arvalid  out  4/ADDR_W/8/3/2/2/4/3/1  AR channel
//  arready                                   in   1   AR accept
//  rid,rdata,rresp,rlast,rvalid              in   4/DATA_W/2/1/1   R channel
//  rready                                    out  1   tied 1
//  awid,awaddr,awlen,awsize,awburst,awlock,awcache,awprot,awvalid  out  as AR  AW channel
//  awready                                   in   1   AW accept
//  wid,wdata,wstrb,wlast,wvalid              out  4/DATA_W/DATA_W/8/1/1   W channel
//  wready                                    in   1   W accept
//  bid,bresp,bvalid                          in   4/2/1   B channel
//  bready                                    out  1   tied 1
// BEHAVIOUR
//  Reset: arvalid/awvalid/wvalid=0; both outstanding counters=0; wr_pend=0; addr_ok/data_ok=0.
//  Constant fields:
//   - arlen=awlen=0, arburst=awburst=2'b01, lock/cache/prot=0, wlast=1.
//   - ar/awsize={1'b0,size}; awid=wid=ID_DATA.
//  Read accept (addr_ok, combinational):
//   - Conditions: port req & !wr & !arvalid & cnt<RD_OUTSTANDING & port is granted.
//   - Data port additionally requires !wr_pend.
//   - Grant: data port wins over inst in the same cycle; inst retries next cycle.
//  On read accept:
//   - araddr/arid latched; arvalid=1 from next cycle.
//   - arvalid drops on arvalid&arready; no new AR accepted while arvalid=1.
//  Write accept (data port only):
//   - Conditions: req & wr & !wr_pend & data rd cnt==0.
//   - Latch awaddr/wdata/wstrb; awvalid=wvalid=1 next cycle; wr_pend=1.
//   - awvalid and wvalid clear independently on their own handshakes.
//  Ordering: data port never mixes reads and writes in flight, so no RAW/WAR hazard logic is needed.
//  Read return:
//   - rvalid&rlast routes by rid; data_ok=1 and rdata=R.rdata in the same cycle (zero added latency).
//   - Unknown rid is dropped.
//  Write return: bvalid&bid==ID_DATA -> data_sram_data_ok=1 same cycle; wr_pend clears.
//  A read and a write completion on the data port in the same cycle is impossible by construction.
//  Counters: +1 on addr_ok (read), -1 on R return. Simultaneous inc+dec leaves the count unchanged.
//   - Width $clog2(RD_OUTSTANDING+1); never wraps.
//  rresp/bresp are ignored; errors do not stall.
//  Reset mid-transaction abandons in-flight AXI traffic; masters must also be in reset.
// STRUCTURE
//  Shared package/header: AXI_BURST_INCR, ID_INST/ID_DATA defaults, SRAM size encodings.
//  Sub-module: bridge_os_cnt (up/down saturating counter with full/empty flags), instantiated per port.
// TESTING
//  1. inst read 0x1C000000, arready=1, R 2 cycles later -> one AR arid=0; inst data_ok with rdata.
//  2. inst+data read same cycle -> data addr_ok first (arid=1); inst addr_ok after arvalid clears.
//  3. RD_OUTSTANDING=2, 3 back-to-back inst reads, R held off -> third addr_ok waits for first R.
//  4. data write 0x800 wstrb 4'b0011, awready delayed 3 cycles, wready=1 -> wvalid drops first;
//     awvalid drops after 3 cycles; data_ok on bvalid.
//  5. data read pending, then data write req -> write addr_ok held until R returns; read after
//     write held until B returns.
//  6. resetn low mid-AR -> arvalid=0 and counters=0 asynchronously; clean restart after release.

Source files
------------

// File: rtl/sram_axi_bridge_pkg.sv
// rtl/sram_axi_bridge_pkg.sv - shared constants and helpers for sram_axi_bridge
// Purpose: AXI constant encodings, default transaction IDs, SRAM size encodings
// and the SRAM-size to AXI-size mapping used by the bridge.
// Ports: none (package).
package sram_axi_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [3:0] ID_INST_DEF = 4'd0;
  localparam logic [3:0] ID_DATA_DEF = 4'd1;

  typedef enum logic [1:0] {
    SRAM_SIZE_BYTE = 2'd0,
    SRAM_SIZE_HALF = 2'd1,
    SRAM_SIZE_WORD = 2'd2
  } sram_size_e;

  // SRAM size codes are log2(bytes), which is exactly the AXI AxSIZE encoding.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/bridge_os_cnt.sv
// rtl/bridge_os_cnt.sv - saturating up/down outstanding-read counter
// Purpose: tracks in-flight reads for one SRAM-like port.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   inc, dec    : one read accepted / one read returned this cycle
//   full        : count has reached MAX
//   empty       : count is zero
module bridge_os_cnt #(
  parameter int MAX = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;
  logic         inc_ok, dec_ok;

  // Saturate at both ends so a stray pulse can never wrap the count.
  assign inc_ok = inc && !full;
  assign dec_ok = dec && !empty;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_ok && !dec_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_ok && !inc_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full  = (cnt_q == MAX_V);
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/sram_axi_bridge.sv
// rtl/sram_axi_bridge.sv - two SRAM-like ports (inst, data) to one AXI3 master
// Purpose: single-beat AXI3 master fed by the core's inst and data SRAM-like
// ports, with per-port outstanding-read limits and a data port that never has
// reads and a write in flight together.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   inst_sram_*          : instruction request port (reads only)
//   data_sram_*          : data request port (reads and writes)
//   ar*/r*               : AXI read address / read data channels
//   aw*/w*/b*            : AXI write address / write data / response channels
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter int         ADDR_W         = 32,
  parameter int         DATA_W         = 32,
  parameter int         RD_OUTSTANDING = 2,
  parameter logic [3:0] ID_INST        = ID_INST_DEF,
  parameter logic [3:0] ID_DATA        = ID_DATA_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_sram_req,
  input  logic                inst_sram_wr,
  input  logic [1:0]          inst_sram_size,
  input  logic [DATA_W/8-1:0] inst_sram_wstrb,
  input  logic [ADDR_W-1:0]   inst_sram_addr,
  input  logic [DATA_W-1:0]   inst_sram_wdata,
  output logic                inst_sram_addr_ok,
  output logic                inst_sram_data_ok,
  output logic [DATA_W-1:0]   inst_sram_rdata,
  input  logic                data_sram_req,
  input  logic                data_sram_wr,
  input  logic [1:0]          data_sram_size,
  input  logic [DATA_W/8-1:0] data_sram_wstrb,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  output logic                data_sram_addr_ok,
  output logic                data_sram_data_ok,
  output logic [DATA_W-1:0]   data_sram_rdata,
  output logic [3:0]          arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [3:0]          rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [3:0]          awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [3:0]          wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [3:0]          bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  logic                arvalid_q, arvalid_d;
  logic [3:0]          arid_q, arid_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [2:0]          arsize_q, arsize_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [2:0]          awsize_q, awsize_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;

  logic inst_full, data_full, data_empty;
  logic inst_cnt_empty_unused;
  logic data_rd_acc, inst_rd_acc, data_wr_acc;
  logic inst_r_ret, data_r_ret, b_ret;
  logic ignored_unused;

  // Responses are never checked and the inst port never writes.
  assign ignored_unused = ^{inst_sram_wstrb, inst_sram_wdata, rresp, bresp};

  // Data reads win the single AR slot; inst simply retries next cycle.
  // Data reads also wait for any write to finish, and data writes wait for
  // all data reads to drain, so the data port never mixes directions.
  assign data_rd_acc = data_sram_req && !data_sram_wr && !arvalid_q && !data_full && !wr_pend_q;
  assign inst_rd_acc = inst_sram_req && !inst_sram_wr && !arvalid_q && !inst_full && !data_rd_acc;
  assign data_wr_acc = data_sram_req && data_sram_wr && !wr_pend_q && data_empty;

  // Returns are forwarded combinationally; unknown IDs fall through unused.
  assign inst_r_ret = rvalid && rlast && (rid == ID_INST);
  assign data_r_ret = rvalid && rlast && (rid == ID_DATA);
  assign b_ret      = bvalid && (bid == ID_DATA);

  bridge_os_cnt #(.MAX(RD_OUTSTANDING)) u_inst_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (inst_rd_acc),
    .dec    (inst_r_ret),
    .full   (inst_full),
    .empty  (inst_cnt_empty_unused)
  );

  bridge_os_cnt #(.MAX(RD_OUTSTANDING)) u_data_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (data_rd_acc),
    .dec    (data_r_ret),
    .full   (data_full),
    .empty  (data_empty)
  );

  always_comb begin
    arvalid_d = arvalid_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wr_pend_d = wr_pend_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;

    if (arvalid_q && arready) begin
      arvalid_d = 1'b0;
    end
    // Accepts are gated on !arvalid_q, so they never collide with a handshake.
    if (data_rd_acc) begin
      arvalid_d = 1'b1;
      arid_d    = ID_DATA;
      araddr_d  = data_sram_addr;
      arsize_d  = axi_size(data_sram_size);
    end else if (inst_rd_acc) begin
      arvalid_d = 1'b1;
      arid_d    = ID_INST;
      araddr_d  = inst_sram_addr;
      arsize_d  = axi_size(inst_sram_size);
    end

    if (awvalid_q && awready) begin
      awvalid_d = 1'b0;
    end
    if (wvalid_q && wready) begin
      wvalid_d = 1'b0;
    end
    if (b_ret) begin
      wr_pend_d = 1'b0;
    end
    if (data_wr_acc) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      wr_pend_d = 1'b1;
      awaddr_d  = data_sram_addr;
      awsize_d  = axi_size(data_sram_size);
      wdata_d   = data_sram_wdata;
      wstrb_d   = data_sram_wstrb;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arsize_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wr_pend_q <= 1'b0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      arvalid_q <= arvalid_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arsize_q  <= arsize_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wr_pend_q <= wr_pend_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign inst_sram_addr_ok = inst_rd_acc;
  assign data_sram_addr_ok = data_rd_acc || data_wr_acc;
  assign inst_sram_data_ok = inst_r_ret;
  assign data_sram_data_ok = data_r_ret || b_ret;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = 8'd0;
  assign arsize  = arsize_q;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = arvalid_q;
  assign rready  = 1'b1;

  assign awid    = ID_DATA;
  assign awaddr  = awaddr_q;
  assign awlen   = 8'd0;
  assign awsize  = awsize_q;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awvalid = awvalid_q;

  assign wid    = ID_DATA;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;
  assign wlast  = 1'b1;
  assign wvalid = wvalid_q;
  assign bready = 1'b1;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb/tb_sram_axi_bridge.sv - randomized scoreboard bench for sram_axi_bridge
module tb_sram_axi_bridge;

  localparam int N_OS = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_sram_req = 1'b0, inst_sram_wr = 1'b0;
  logic [1:0]  inst_sram_size = 2'd2;
  logic [3:0]  inst_sram_wstrb = 4'h0;
  logic [31:0] inst_sram_addr = '0, inst_sram_wdata = '0;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req = 1'b0, data_sram_wr = 1'b0;
  logic [1:0]  data_sram_size = 2'd2;
  logic [3:0]  data_sram_wstrb = 4'h0;
  logic [31:0] data_sram_addr = '0, data_sram_wdata = '0;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, awid, wid;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, awvalid, wvalid, wlast, rready, bready;
  logic        arready = 1'b0, awready = 1'b0, wready = 1'b0;
  logic [3:0]  rid = '0, bid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0, bresp = '0;
  logic        rlast = 1'b0, rvalid = 1'b0, bvalid = 1'b0;

  sram_axi_bridge #(.RD_OUTSTANDING(N_OS)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Transaction-level reference state.
  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    int          due;
  } rd_ent_t;

  rd_ent_t     sl_r[$];
  logic [31:0] q_i[$];
  logic [31:0] q_d[$];
  bit          ar_busy, aw_busy, w_busy, wr_pend, aw_done, w_done, b_sched;
  int          cnt_i, cnt_d, b_due;
  bit          i_acc, d_acc, r_pop, b_pop;
  logic [3:0]  exp_arid;
  logic [31:0] exp_araddr, exp_awaddr, exp_wdata;
  logic [2:0]  exp_arsize, exp_awsize;
  logic [3:0]  exp_wstrb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic model_reset();
    sl_r.delete(); q_i.delete(); q_d.delete();
    ar_busy = 0; aw_busy = 0; w_busy = 0; wr_pend = 0;
    aw_done = 0; w_done = 0; b_sched = 0;
    cnt_i = 0; cnt_d = 0; b_due = 0;
    i_acc = 0; d_acc = 0; r_pop = 0; b_pop = 0;
  endtask

  task automatic run_cycle(input bit hold_ar);
    bit          e_dr, e_dw, e_i, e_iok, e_dok;
    logic [31:0] a;
    @(posedge clk);
    cyc++;
    #1;
    if (i_acc) inst_sram_req = 1'b0;
    if (d_acc) data_sram_req = 1'b0;
    i_acc = 0;
    d_acc = 0;
    if (!inst_sram_req && $urandom_range(0, 3) != 0) begin
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'h1C00_0000 | 32'($urandom_range(0, 255) << 2);
    end
    if (!data_sram_req && $urandom_range(0, 2) != 0) begin
      data_sram_req   = 1'b1;
      data_sram_wr    = ($urandom_range(0, 2) == 0);
      data_sram_size  = 2'($urandom_range(0, 2));
      data_sram_addr  = 32'h0000_0800 + 32'($urandom_range(0, 63) << 2);
      data_sram_wdata = $urandom;
      data_sram_wstrb = 4'($urandom_range(1, 15));
    end
    arready = hold_ar ? 1'b0 : ($urandom_range(0, 2) != 0);
    awready = ($urandom_range(0, 3) != 0);
    wready  = ($urandom_range(0, 3) != 0);

    r_pop = 0; rvalid = 1'b0; rid = '0; rdata = '0; rlast = 1'b0; rresp = '0;
    if ($urandom_range(0, 19) == 0) begin
      rvalid = 1'b1; rid = 4'd5; rdata = $urandom; rlast = 1'b1; rresp = 2'b10;
    end else if (sl_r.size() > 0 && sl_r[0].due <= cyc && (cyc % 200) >= 30) begin
      rvalid = 1'b1; rid = sl_r[0].id; rdata = rd_hash(sl_r[0].addr); rlast = 1'b1;
      rresp = 2'($urandom_range(0, 3));
      r_pop = 1;
    end
    b_pop = 0; bvalid = 1'b0; bid = '0; bresp = '0;
    if (b_sched && b_due <= cyc) begin
      bvalid = 1'b1; bid = 4'd1; bresp = 2'($urandom_range(0, 3)); b_pop = 1;
    end else if ($urandom_range(0, 24) == 0) begin
      bvalid = 1'b1; bid = 4'd3;
    end

    @(negedge clk);
    e_dr  = data_sram_req && !data_sram_wr && !ar_busy && cnt_d < N_OS && !wr_pend;
    e_dw  = data_sram_req && data_sram_wr && !wr_pend && cnt_d == 0;
    e_i   = inst_sram_req && !ar_busy && cnt_i < N_OS && !e_dr;
    e_iok = rvalid && rid == 4'd0;
    e_dok = (rvalid && rid == 4'd1) || (bvalid && bid == 4'd1);
    check("inst_addr_ok", inst_sram_addr_ok, e_i);
    check("data_addr_ok", data_sram_addr_ok, e_dr || e_dw);
    check("inst_data_ok", inst_sram_data_ok, e_iok);
    check("data_data_ok", data_sram_data_ok, e_dok);
    check("arvalid", arvalid, ar_busy);
    check("awvalid", awvalid, aw_busy);
    check("wvalid", wvalid, w_busy);

    if (ar_busy && arready) begin
      check("arid", arid, exp_arid);
      check("araddr", araddr, exp_araddr);
      check("arsize", arsize, exp_arsize);
      sl_r.push_back('{id: exp_arid, addr: exp_araddr, due: cyc + 1 + int'($urandom_range(0, 5))});
      ar_busy = 0;
    end
    if (aw_busy && awready) begin
      check("awaddr", awaddr, exp_awaddr);
      check("awsize", awsize, exp_awsize);
      check("awid", awid, 4'd1);
      aw_busy = 0; aw_done = 1;
    end
    if (w_busy && wready) begin
      check("wdata", wdata, exp_wdata);
      check("wstrb", wstrb, exp_wstrb);
      check("wid", wid, 4'd1);
      w_busy = 0; w_done = 1;
    end
    if (aw_done && w_done && !b_sched) begin
      b_sched = 1; b_due = cyc + 1 + int'($urandom_range(0, 4));
      aw_done = 0; w_done = 0;
    end
    if (r_pop) void'(sl_r.pop_front());

    if (e_iok) begin
      if (q_i.size() == 0) check("inst_ret_unexpected", 1, 0);
      else begin
        a = q_i.pop_front();
        check("inst_rdata", inst_sram_rdata, rd_hash(a));
        cnt_i--;
      end
    end
    if (rvalid && rid == 4'd1) begin
      if (q_d.size() == 0) check("data_ret_unexpected", 1, 0);
      else begin
        a = q_d.pop_front();
        check("data_rdata", data_sram_rdata, rd_hash(a));
        cnt_d--;
      end
    end
    if (b_pop) begin
      wr_pend = 0; b_sched = 0;
    end

    if (e_dr) begin
      ar_busy = 1; exp_arid = 4'd1; exp_araddr = data_sram_addr;
      exp_arsize = {1'b0, data_sram_size};
      q_d.push_back(data_sram_addr); cnt_d++; d_acc = 1;
    end else if (e_i) begin
      ar_busy = 1; exp_arid = 4'd0; exp_araddr = inst_sram_addr;
      exp_arsize = {1'b0, inst_sram_size};
      q_i.push_back(inst_sram_addr); cnt_i++; i_acc = 1;
    end
    if (e_dw) begin
      wr_pend = 1; aw_busy = 1; w_busy = 1;
      exp_awaddr = data_sram_addr; exp_awsize = {1'b0, data_sram_size};
      exp_wdata = data_sram_wdata; exp_wstrb = data_sram_wstrb;
      d_acc = 1;
    end
  endtask

  task automatic idle_inputs();
    inst_sram_req = 1'b0; data_sram_req = 1'b0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rvalid = 1'b0; rlast = 1'b0; bvalid = 1'b0;
  endtask

  initial begin
    int budget;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_inst_data_ok", inst_sram_data_ok, 0);
    check("rst_data_data_ok", data_sram_data_ok, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("arlen", arlen, 0);
    check("awlen", awlen, 0);
    check("arburst", arburst, 2'b01);
    check("awburst", awburst, 2'b01);
    check("ar_lock_cache_prot", {arlock, arcache, arprot}, 0);
    check("aw_lock_cache_prot", {awlock, awcache, awprot}, 0);
    check("wlast", wlast, 1);
    check("rready_bready", {rready, bready}, 2'b11);

    repeat (2000) run_cycle(1'b0);

    // Park a read on AR, then pull reset asynchronously mid-cycle.
    budget = 0;
    while (!ar_busy && budget < 300) begin
      run_cycle(1'b1);
      budget++;
    end
    check("rst_ar_pending_seen", ar_busy, 1);
    @(posedge clk);
    #1;
    idle_inputs();
    check("pre_rst_arvalid", arvalid, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_arvalid", arvalid, 0);
    check("async_rst_awvalid", awvalid, 0);
    check("async_rst_wvalid", wvalid, 0);
    check("async_rst_addr_ok", {inst_sram_addr_ok, data_sram_addr_ok}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();

    repeat (1500) run_cycle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
